// File: rtl/clock_ctrl_if.sv
// Signal bundle between the alarm-clock front panel/counters and the clock_ctrl sequencer.
// There is no handshake: every input is a level or one-clk strobe sampled on each clk edge.
interface clock_ctrl_if;
  // Inputs to the sequencer
  logic       tick;
  logic       timeset;
  logic       alarmset;
  logic       minadv;
  logic       hrsadv;
  logic       alarmon;
  logic       snooze;
  logic       s_max;
  logic       m_max;
  logic       alarm_match;

  // Outputs from the sequencer
  logic       sec_en;
  logic       tmin_en;
  logic       thrs_en;
  logic       amin_en;
  logic       ahrs_en;
  logic       disp_alarm;
  logic       buzz;
  logic [1:0] mode;
  logic [1:0] alarm_state;  // debug view of the alarm FSM: 0 idle, 1 ring, 2 snooze

  modport slave (
    input  tick, timeset, alarmset, minadv, hrsadv, alarmon, snooze,
           s_max, m_max, alarm_match,
    output sec_en, tmin_en, thrs_en, amin_en, ahrs_en, disp_alarm, buzz,
           mode, alarm_state
  );

  modport master (
    output tick, timeset, alarmset, minadv, hrsadv, alarmon, snooze,
           s_max, m_max, alarm_match,
    input  sec_en, tmin_en, thrs_en, amin_en, ahrs_en, disp_alarm, buzz,
           mode, alarm_state
  );
endinterface

// File: rtl/clock_ctrl.sv
// Mode register, counter-enable decode and ring/snooze/timeout alarm sequencer
// for the alarm-clock datapath.
module clock_ctrl #(
  parameter int NS       = 60,
  parameter int NH       = 24,
  parameter int SNOOZE_S = 540,
  parameter int RING_S   = 60
) (
  input  logic         clk,
  input  logic         rst,
  clock_ctrl_if.slave  bus
);

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_TSET = 2'd1;
  localparam logic [1:0] MODE_ASET = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam int RW = $clog2(RING_S);
  localparam int SW = $clog2(SNOOZE_S + 1);

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_S - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_S);
  localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);

  if (NS < 2 || NH < 2 || RING_S < 2 || SNOOZE_S < 1) begin : g_bad_param
    $error("clock_ctrl: moduli and ring length must be >= 2, snooze length >= 1");
  end

  // ---------------------------------------------------------------
  // Mode register
  // ---------------------------------------------------------------
  logic [1:0] mode_q;
  logic [1:0] mode_d;

  always_comb begin
    mode_d = MODE_RUN;
    if (bus.timeset) begin
      mode_d = MODE_TSET;
    end else if (bus.alarmset) begin
      mode_d = MODE_ASET;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // ---------------------------------------------------------------
  // Counter enables; forced low while reset is asserted
  // ---------------------------------------------------------------
  logic sec_en;
  logic tmin_en;
  logic thrs_en;
  logic amin_en;
  logic ahrs_en;

  always_comb begin
    sec_en  = 1'b0;
    tmin_en = 1'b0;
    thrs_en = 1'b0;
    amin_en = 1'b0;
    ahrs_en = 1'b0;
    if (rst) begin
      case (mode_q)
        MODE_RUN: begin
          sec_en  = bus.tick;
          tmin_en = bus.tick & bus.s_max;
          thrs_en = bus.tick & bus.s_max & bus.m_max;
        end
        MODE_TSET: begin
          // Seconds frozen; hour advance carries nothing from minutes
          tmin_en = bus.tick & bus.minadv;
          thrs_en = bus.tick & bus.hrsadv;
        end
        MODE_ASET: begin
          sec_en  = bus.tick;
          tmin_en = bus.tick & bus.s_max;
          thrs_en = bus.tick & bus.s_max & bus.m_max;
          amin_en = bus.tick & bus.minadv;
          ahrs_en = bus.tick & bus.hrsadv;
        end
        default: begin
          sec_en = 1'b0;
        end
      endcase
    end
  end

  assign bus.sec_en     = sec_en;
  assign bus.tmin_en    = tmin_en;
  assign bus.thrs_en    = thrs_en;
  assign bus.amin_en    = amin_en;
  assign bus.ahrs_en    = ahrs_en;
  assign bus.disp_alarm = (mode_q == MODE_ASET);
  assign bus.mode       = mode_q;

  // ---------------------------------------------------------------
  // Alarm FSM
  // ---------------------------------------------------------------
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [RW-1:0] ring_ct_q;
  logic [RW-1:0] ring_ct_d;
  logic [SW-1:0] snz_ct_q;
  logic [SW-1:0] snz_ct_d;
  logic          match_dly;
  logic          snooze_dly;
  logic          buzz_q;
  logic          trigger;
  logic          snooze_edge;

  // Only the rising edge of match rings, so a dismissed alarm stays quiet for the rest of that minute
  assign trigger     = bus.alarm_match & ~match_dly & bus.alarmon & (mode_q != MODE_TSET);
  assign snooze_edge = bus.snooze & ~snooze_dly;

  always_comb begin
    state_d   = state_q;
    ring_ct_d = ring_ct_q;
    snz_ct_d  = snz_ct_q;
    if (mode_q == MODE_TSET) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d   = ST_RING;
            ring_ct_d = '0;
          end
        end
        ST_RING: begin
          if (!bus.alarmon) begin
            state_d = ST_IDLE;
          end else if (snooze_edge) begin
            state_d  = ST_SNOOZE;
            snz_ct_d = SNOOZE_LOAD;
          end else if (bus.tick) begin
            if (ring_ct_q >= RING_LAST) begin
              state_d = ST_IDLE;
            end else begin
              ring_ct_d = ring_ct_q + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (!bus.alarmon) begin
            state_d = ST_IDLE;
          end else if (bus.tick) begin
            if (snz_ct_q <= SNOOZE_ONE) begin
              state_d   = ST_RING;
              ring_ct_d = '0;
            end else begin
              snz_ct_d = snz_ct_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ring_ct_q  <= '0;
      snz_ct_q   <= '0;
      match_dly  <= 1'b0;
      snooze_dly <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_ct_q  <= ring_ct_d;
      snz_ct_q   <= snz_ct_d;
      match_dly  <= bus.alarm_match;
      snooze_dly <= bus.snooze;
      buzz_q     <= (state_d == ST_RING);
    end
  end

  assign bus.buzz        = buzz_q;
  assign bus.alarm_state = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: cycle-by-cycle expected outputs from a behavioural alarm-clock
// model are queued by the driver and popped/compared by an independent negedge monitor.
module tb_clock_ctrl;

  localparam int SNOOZE_S = 540;
  localparam int RING_S   = 60;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  clock_ctrl_if bus();

  clock_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- stimulus levels ----------------
  logic rst_v;
  logic i_tick, i_ts, i_as, i_madv, i_hadv, i_aon, i_snz, i_smax, i_mmax, i_match;
  string phase;

  // ---------------- reference model ----------------
  int m_mode;        // 0 run, 1 time set, 2 alarm set
  bit m_ring;        // alarm is sounding
  bit m_snoozing;    // waiting out a snooze
  int m_rung;        // ticks heard during the current ring
  int m_snz_left;    // ticks left before snooze expires
  bit m_match_prev;
  bit m_snz_prev;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  string      lbl_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void model_reset();
    m_mode       = 0;
    m_ring       = 0;
    m_snoozing   = 0;
    m_rung       = 0;
    m_snz_left   = 0;
    m_match_prev = 0;
    m_snz_prev   = 0;
  endfunction

  function automatic void model_edge();
    bit trig;
    bit snz_rise;
    trig     = i_match && !m_match_prev && i_aon && (m_mode != 1);
    snz_rise = i_snz && !m_snz_prev;
    if (m_mode == 1) begin
      m_ring     = 0;
      m_snoozing = 0;
    end else if (m_ring) begin
      if (!i_aon) begin
        m_ring = 0;
      end else if (snz_rise) begin
        m_ring     = 0;
        m_snoozing = 1;
        m_snz_left = SNOOZE_S;
      end else if (i_tick) begin
        m_rung++;
        if (m_rung == RING_S) m_ring = 0;
      end
    end else if (m_snoozing) begin
      if (!i_aon) begin
        m_snoozing = 0;
      end else if (i_tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_snoozing = 0;
          m_ring     = 1;
          m_rung     = 0;
        end
      end
    end else if (trig) begin
      m_ring = 1;
      m_rung = 0;
    end
    m_match_prev = i_match;
    m_snz_prev   = i_snz;
    m_mode       = i_ts ? 1 : (i_as ? 2 : 0);
  endfunction

  // {sec_en, tmin_en, thrs_en, amin_en, ahrs_en, disp_alarm, buzz, mode[1:0]}
  function automatic logic [8:0] expect_now();
    bit run_like;
    bit sec, tmin, thrs, amin, ahrs, disp;
    run_like = (m_mode != 1);
    sec  = rst_v && i_tick && run_like;
    tmin = rst_v && i_tick && (run_like ? i_smax : i_madv);
    thrs = rst_v && i_tick && (run_like ? (i_smax && i_mmax) : i_hadv);
    amin = rst_v && i_tick && (m_mode == 2) && i_madv;
    ahrs = rst_v && i_tick && (m_mode == 2) && i_hadv;
    disp = (m_mode == 2);
    return {sec, tmin, thrs, amin, ahrs, disp, m_ring, 2'(m_mode)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    i_tick = 0; i_ts = 0; i_as = 0; i_madv = 0; i_hadv = 0;
    i_aon = 0; i_snz = 0; i_smax = 0; i_mmax = 0; i_match = 0;
  endtask

  // Called just after a posedge: apply levels, queue this cycle's expectation, cross the next edge.
  task automatic step();
    rst             = rst_v;
    bus.tick        = i_tick;
    bus.timeset     = i_ts;
    bus.alarmset    = i_as;
    bus.minadv      = i_madv;
    bus.hrsadv      = i_hadv;
    bus.alarmon     = i_aon;
    bus.snooze      = i_snz;
    bus.s_max       = i_smax;
    bus.m_max       = i_mmax;
    bus.alarm_match = i_match;
    if (!rst_v) model_reset();
    exp_q.push_back(expect_now());
    lbl_q.push_back(phase);
    @(posedge clk);
    if (rst_v) model_edge();
    #1;
  endtask

  task automatic ticks(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      i_tick = 1;
      step();
      i_tick = 0;
      repeat ($urandom_range(0, max_gap)) step();
    end
  endtask

  // ---------------- monitor ----------------
  logic [8:0] mon_exp;
  logic [8:0] mon_act;
  string      mon_lbl;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_lbl = lbl_q.pop_front();
      mon_act = {bus.sec_en, bus.tmin_en, bus.thrs_en, bus.amin_en, bus.ahrs_en,
                 bus.disp_alarm, bus.buzz, bus.mode};
      n_checks++;
      if (mon_act === mon_exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d got={sec,tmin,thrs,amin,ahrs,disp,buzz,mode}=%b exp=%b",
                 mon_lbl, cyc, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst   = 1'b0;
    rst_v = 1'b0;
    clear_in();
    model_reset();
    phase = "init";
    @(posedge clk);
    #1;

    phase = "reset_gates_enables";
    i_tick = 1; i_smax = 1; i_mmax = 1; i_as = 1;
    repeat (3) step();
    rst_v = 1;
    clear_in();
    step();

    phase = "run_carry";
    i_smax = 1; i_mmax = 1; i_tick = 1; step();
    i_mmax = 0; step();
    i_tick = 0; step();
    i_smax = 0; i_tick = 1; step();

    phase = "tset_priority";
    clear_in();
    i_ts = 1; i_as = 1; i_madv = 1;
    step();
    repeat (5) begin
      i_tick = 1; i_smax = 1; step();
      i_tick = 0; step();
    end
    i_hadv = 1; i_tick = 1; step();
    i_tick = 0;

    phase = "tset_release";
    i_ts = 0; i_hadv = 0;
    step(); step();

    phase = "aset_adv";
    i_hadv = 1; i_madv = 1; i_tick = 1; i_smax = 1; i_mmax = 1;
    repeat (3) step();
    clear_in();
    step(); step();

    phase = "ring_timeout";
    i_aon = 1; step();
    i_match = 1; step();
    ticks(RING_S + 5, 2);
    i_match = 0; step();

    phase = "snooze";
    i_match = 1; step();
    ticks(3, 1);
    i_snz = 1; step();
    i_snz = 0; step();
    ticks(SNOOZE_S, 0);
    ticks(2, 1);
    i_aon = 0; step(); step();
    i_match = 0; step();

    phase = "same_clk_priority";
    i_aon = 1; step();
    i_match = 1; step(); step();
    i_snz = 1; i_aon = 0; step();
    i_snz = 0; i_aon = 1; step();
    ticks(3, 1);
    i_match = 0; step();

    phase = "tset_cancel";
    i_match = 1; step();
    ticks(2, 1);
    i_ts = 1; step(); step(); step();
    i_ts = 0; i_match = 0; step(); step();

    phase = "snooze_held";
    i_snz = 1; i_match = 1; step();
    ticks(5, 1);
    i_snz = 0; step();
    i_aon = 0; step();
    i_match = 0; step();

    phase = "reset_mid_ring";
    i_aon = 1; step();
    i_match = 1; step();
    ticks(2, 1);
    rst_v = 0; step();
    rst_v = 1; clear_in();
    ticks(10, 2);

    phase = "match_at_release";
    i_aon = 1; i_match = 1;
    rst_v = 0; step();
    rst_v = 1; step(); step();
    ticks(3, 1);
    i_aon = 0; step();
    clear_in(); step();

    phase = "random";
    repeat (3000) begin
      i_tick = ($urandom_range(0, 3) == 0);
      i_smax = ($urandom_range(0, 2) == 0);
      i_mmax = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) i_ts    = ~i_ts;
      if ($urandom_range(0, 19) == 0) i_as    = ~i_as;
      if ($urandom_range(0, 9)  == 0) i_madv  = ~i_madv;
      if ($urandom_range(0, 9)  == 0) i_hadv  = ~i_hadv;
      if ($urandom_range(0, 99) == 0) i_aon   = ~i_aon;
      if ($urandom_range(0, 39) == 0) i_match = ~i_match;
      if ($urandom_range(0, 24) == 0) i_snz   = ~i_snz;
      if (i_ts && $urandom_range(0, 3) != 0) i_ts = 0;
      step();
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
